// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: FSM encodings, the settle counter
// width and the default select width.
package mux_scan_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W     = 8;
  localparam int DEF_SEL_W = 2;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan sequencer <-> mux/consumer bundle: select out, mux output in, and the
// start request plus the valid/ready packed-word handshake.
interface mux_scan_sequencer_if #(
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic             start;
  logic             f;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [N-1:0]     data;

  modport master (
    input  start, f, ready,
    output sel, busy, valid, data
  );

  modport slave (
    output start, f, ready,
    input  sel, busy, valid, data
  );
endinterface

// File: rtl/mux_scan_settle_cnt.sv
// Per-channel settle timer: counts while enabled and flags the last cycle of the
// settle window with tick, wrapping to zero on that cycle.
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick and next count
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TICK_AT) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through every channel, samples f after a settle time
// and offers the packed word on valid/ready. MUX_SCAN_CONTINUOUS_EN: restart on handshake.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SEL_W      = DEF_SEL_W,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sequencer_if.master bus
);

  localparam int               N        = 1 << SEL_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     data_q, data_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             tick;
  logic             scan_en;

  assign scan_en = (state_q == ST_SCAN);

  mux_scan_settle_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle (
    .clk (clk),
    .rst (rst),
    .clr (~scan_en),
    .en  (scan_en),
    .tick(tick)
  );

  // next state, select and sample word
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (bus.start) begin
          state_d = ST_SCAN;
          data_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          data_d[sel_q] = bus.f;
          if (sel_q == SEL_LAST) begin
            state_d = ST_DONE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here; it is never queued
        if (bus.ready) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          state_d = ST_SCAN;
          data_d  = '0;
`else
          state_d = ST_IDLE;
`endif
          sel_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        data_d  = '0;
      end
    endcase
    busy_d  = (state_d == ST_SCAN);
    valid_d = (state_d == ST_DONE);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and 3) each scanning a modelled
// 4:1 mux; expectations come from the scan timing rules and the mux input word.
module tb_mux_scan_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_scan_sequencer_if #(.SEL_W(2)) b1 ();
  mux_scan_sequencer_if #(.SEL_W(2)) b3 ();

  mux_scan_sequencer #(.SEL_W(2), .SETTLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  mux_scan_sequencer #(.SEL_W(2), .SETTLE_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.master));

  logic       start_a [2];
  logic       ready_a [2];
  logic [3:0] iv_a    [2];

  // mux models: f = I[sel]
  assign b1.start = start_a[0];
  assign b1.ready = ready_a[0];
  assign b1.f     = iv_a[0][b1.sel];
  assign b3.start = start_a[1];
  assign b3.ready = ready_a[1];
  assign b3.f     = iv_a[1][b3.sel];

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] o_sel(int i);
    if (i == 0) return b1.sel; else return b3.sel;
  endfunction
  function automatic logic o_busy(int i);
    if (i == 0) return b1.busy; else return b3.busy;
  endfunction
  function automatic logic o_valid(int i);
    if (i == 0) return b1.valid; else return b3.valid;
  endfunction
  function automatic logic [3:0] o_data(int i);
    if (i == 0) return b1.data; else return b3.data;
  endfunction
  function automatic int settle(int i);
    if (i == 0) return 1; else return 3;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag, int i);
    chk({tag, "_sel"}, 32'(o_sel(i)), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy(i)), 32'd0);
    chk({tag, "_valid"}, 32'(o_valid(i)), 32'd0);
    chk({tag, "_data"}, 32'(o_data(i)), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One full scan: expected sel at cycle t after accept is t/settle, valid at N*settle
  task automatic run_scan(int i, logic [3:0] word, int hold, bit poke);
    int s;
    s = settle(i);
    iv_a[i]    = word;
    start_a[i] = 1'b1;
    step();
    start_a[i] = 1'b0;
    chk("scan_clr", 32'(o_data(i)), 32'd0);
    for (int t = 0; t < N * s; t++) begin
      chk("scan_sel", 32'(o_sel(i)), 32'(t / s));
      chk("scan_busy", 32'(o_busy(i)), 32'd1);
      chk("scan_valid", 32'(o_valid(i)), 32'd0);
      start_a[i] = poke && (t == 1);
      step();
    end
    start_a[i] = 1'b0;
    chk("done_valid", 32'(o_valid(i)), 32'd1);
    chk("done_busy", 32'(o_busy(i)), 32'd0);
    chk("done_data", 32'(o_data(i)), 32'(word));
    chk("done_sel", 32'(o_sel(i)), 32'd3);
    for (int h = 0; h < hold; h++) begin
      ready_a[i] = 1'b0;
      start_a[i] = poke;
      step();
      chk("hold_valid", 32'(o_valid(i)), 32'd1);
      chk("hold_data", 32'(o_data(i)), 32'(word));
      chk("hold_sel", 32'(o_sel(i)), 32'd3);
      chk("hold_busy", 32'(o_busy(i)), 32'd0);
    end
    ready_a[i] = 1'b1;
    start_a[i] = poke;
    step();
    ready_a[i] = 1'b0;
    start_a[i] = 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
    chk("restart_busy", 32'(o_busy(i)), 32'd1);
    chk("restart_valid", 32'(o_valid(i)), 32'd0);
    chk("restart_data", 32'(o_data(i)), 32'd0);
    pulse_reset();
`else
    chk("idle_valid", 32'(o_valid(i)), 32'd0);
    chk("idle_busy", 32'(o_busy(i)), 32'd0);
    chk("idle_sel", 32'(o_sel(i)), 32'd0);
    chk("idle_data", 32'(o_data(i)), 32'(word));
    step();
    chk("idle_noqueue", 32'(o_busy(i)), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      ready_a[i] = 1'b0;
      iv_a[i]    = 4'd0;
    end
    #22;
    chk_zero("reset1", 0);
    chk_zero("reset3", 1);
    rst = 1'b0;
    step();

    run_scan(0, 4'b1010, 0, 1'b0);
    run_scan(1, 4'b0110, 0, 1'b0);
    run_scan(0, 4'b1001, 5, 1'b1);

    // asynchronous reset while sel = 2
    iv_a[0]    = 4'b1111;
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    step();
    step();
    chk("pre_rst_sel", 32'(o_sel(0)), 32'd2);
    chk("pre_rst_data", 32'(o_data(0)), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst", 0);
    rst = 1'b0;
    step();
    run_scan(0, 4'b0111, 0, 1'b0);

    for (int v = 0; v < 16; v++) begin
      run_scan(0, 4'(v), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 5; k++) begin
      run_scan(1, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

`ifdef MUX_SCAN_CONTINUOUS_EN
    // ready held high: valid every N+1 cycles from the first word on
    iv_a[0]    = 4'b1100;
    ready_a[0] = 1'b1;
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("cont_valid", 32'(o_valid(0)), 32'((c >= N) && ((c - N) % (N + 1) == 0)));
      if (o_valid(0)) chk("cont_data", 32'(o_data(0)), 32'(4'b1100));
      step();
    end
    ready_a[0] = 1'b0;
    pulse_reset();
    step();
    chk_zero("cont_stop", 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
